// File: rtl/event_dispatch_if.sv
// Bundle between the event producers, the CSR event block and event_dispatch.
interface event_dispatch_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TYPE_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              io_evt_valid;
    logic              io_evt_ready;
    logic [TYPE_W-1:0] io_evt_type;
    logic              io_has_event_rd;
    logic [31:0]       io_event_recv_cnt;
    logic [31:0]       io_event_processed_cnt;
    logic              io_has_event_wr;
    logic [TYPE_W-1:0] io_event_type_wr;
    logic [CNT_W-1:0]  io_pending_cnt;
    logic [7:0]        io_retry_cnt;

    // Dispatcher view.
    modport slave (
        input  io_evt_valid, io_evt_type, io_has_event_rd,
               io_event_recv_cnt, io_event_processed_cnt,
        output io_evt_ready, io_has_event_wr, io_event_type_wr,
               io_pending_cnt, io_retry_cnt
    );

    // Producer / CSR view.
    modport master (
        output io_evt_valid, io_evt_type, io_has_event_rd,
               io_event_recv_cnt, io_event_processed_cnt,
        input  io_evt_ready, io_has_event_wr, io_event_type_wr,
               io_pending_cnt, io_retry_cnt
    );
endinterface

// File: rtl/event_dispatch.sv
// Event FIFO feeding the CSR event interface; issues only when the CSR is idle,
// confirms each hand-off via the CSR receive counter and re-issues on timeout.
module event_dispatch #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TYPE_W      = 32,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic             clock,
    input  logic             reset,
    event_dispatch_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [TYPE_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [31:0]       r_snap;
    logic [31:0]       w_snap_nxt;
    logic [TMR_W-1:0]  r_timer;
    logic [TMR_W-1:0]  w_timer_nxt;

    logic              r_has_event_wr;
    logic [TYPE_W-1:0] r_event_type_wr;
    logic [7:0]        r_retry_cnt;

    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic              w_retry;
    logic              w_csr_idle;
    logic              w_ack;
    logic              w_ready;

    assign w_ready    = (r_count != CNT_W'(DEPTH));
    assign w_push     = bus.io_evt_valid && w_ready;
    assign w_csr_idle = !bus.io_has_event_rd &&
                        (bus.io_event_recv_cnt == bus.io_event_processed_cnt);
    // Inequality rather than ordering so a 32-bit counter wrap still acknowledges.
    assign w_ack      = (bus.io_event_recv_cnt != r_snap);

    // Next-state and control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_snap_nxt  = r_snap;
        w_timer_nxt = r_timer;
        w_pop       = 1'b0;
        w_issue     = 1'b0;
        w_retry     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_count != '0) && w_csr_idle) begin
                    w_snap_nxt  = bus.io_event_recv_cnt;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_issue     = 1'b1;
                w_timer_nxt = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_ack) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                    w_retry     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state, acknowledge snapshot and timeout timer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_snap  <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_snap  <= w_snap_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // FIFO storage; contents need no reset since count/pointers define validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.io_evt_type;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered CSR-side outputs: strobe, descriptor and retry counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_has_event_wr  <= 1'b0;
            r_event_type_wr <= '0;
            r_retry_cnt     <= '0;
        end else begin
            r_has_event_wr <= w_issue;
            if (w_issue) begin
                r_event_type_wr <= r_mem[r_rd_ptr];
            end
            if (w_retry && (r_retry_cnt != 8'hFF)) begin
                r_retry_cnt <= r_retry_cnt + 8'd1;
            end
        end
    end

    assign bus.io_evt_ready     = w_ready;
    assign bus.io_has_event_wr  = r_has_event_wr;
    assign bus.io_event_type_wr = r_event_type_wr;
    assign bus.io_pending_cnt   = r_count;
    assign bus.io_retry_cnt     = r_retry_cnt;
endmodule
